// File: rtl/trp_ctrl_pkg.sv
// ============================================================================
// Module  : trp_pkg
// Brief   : Shared types for the transpose-buffer controller: job mode
//           encoding, FSM state enum and a mode legality helper.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package trp_pkg;

  // Job mode as seen on mode_in / mode; 2'b00 and 2'b11 are illegal requests
  typedef enum logic [1:0] {
    MODE_NONE  = 2'b00,
    BIT8_MODE  = 2'b01,
    BIT32_MODE = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  // True only for the two job modes the buffer understands
  function automatic logic mode_legal(input logic [1:0] m);
    return (m == BIT8_MODE) || (m == BIT32_MODE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/trp_ctrl_if.sv
// ============================================================================
// Module  : trp_ctrl_if
// Brief   : Row-write stream (in_*) and transposed-row stream (out_*) of the
//           transpose controller. The master side feeds rows and consumes
//           transposed rows; the slave side is the controller.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface trp_ctrl_if #(
  parameter int BUFFD = 64
) ();

  logic                 in_vld;
  logic                 in_rdy;
  logic [BUFFD*8-1:0]   in_data;
  logic                 out_vld;
  logic                 out_rdy;
  logic [BUFFD*8-1:0]   out_data;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data
  );

endinterface

`default_nettype wire

// File: rtl/trp_ctrl_obuf.sv
// ============================================================================
// Module  : trp_ctrl_obuf
// Brief   : Two-entry FIFO holding transposed rows returned by the buffer.
//           Head entry is presented on o_out_data and stays put until popped.
//           Overflow is prevented upstream by the read-credit rule.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module trp_ctrl_obuf #(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic          o_out_vld,
  output logic [DW-1:0] o_out_data,
  output logic [1:0]    o_occ
);

  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_cnt;

  // Storage, pointers and occupancy; flush drops every held entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else if (i_flush) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_out_vld  = (r_cnt != 2'd0);
  assign o_out_data = o_out_vld ? r_mem[r_rptr] : '0;
  assign o_occ      = r_cnt;

endmodule

`default_nettype wire

// File: rtl/trp_ctrl.sv
// ============================================================================
// Module  : trp_ctrl
// Brief   : Transpose-buffer controller. Loads BUFFD rows into an external
//           transpose buffer, then drains transposed rows through a 2-entry
//           output FIFO using a read-credit scheme (at most two rows held or
//           in flight). Optional abort input when TRP_CTRL_ABORT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module trp_ctrl
  import trp_pkg::*;
#(
  parameter int BUFFD = 64
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef TRP_CTRL_ABORT_EN
  input  logic               abort,
`endif
  input  logic               start,
  input  logic [1:0]         mode_in,
  trp_ctrl_if.slave          bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         mode,
  output logic               ffinit,
  output logic               ffwreq,
  output logic               ffrreq,
  output logic [BUFFD*8-1:0] ffwdata,
  input  logic [BUFFD*8-1:0] ffrdata,
  input  logic               ffrvld
);

  localparam int c_dw = BUFFD * 8;
  localparam int c_cw = $clog2(BUFFD + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  mode_t           r_mode;
  logic [c_cw-1:0] r_wcnt;
  logic [c_cw-1:0] r_rcnt;
  logic            r_inflight;

  logic            w_start_ok;
  logic            w_accept;
  logic            w_abort;
  logic            w_pop;
  logic            w_push;
  logic            w_credit_ok;
  logic            w_rd_all;
  logic            w_last_row;
  logic [c_cw-1:0] w_rlen;
  logic [1:0]      w_occ;
  logic            w_ovld;
  logic [c_dw-1:0] w_odata;

`ifdef TRP_CTRL_ABORT_EN
  assign w_abort = abort && ((r_state == LOAD) || (r_state == DRAIN));
`else
  assign w_abort = 1'b0;
`endif

  assign w_start_ok  = (r_state == IDLE) && start && mode_legal(mode_in);
  assign w_accept    = bus.in_vld && (r_state == LOAD) && !w_abort;
  assign w_last_row  = (r_wcnt == c_cw'(BUFFD - 1));
  assign w_rlen      = (r_mode == BIT32_MODE) ? c_cw'(BUFFD / 4) : c_cw'(BUFFD);
  assign w_rd_all    = (r_rcnt == w_rlen);
  assign w_pop       = w_ovld && bus.out_rdy;
  // occupancy + inflight - pop < 2, rearranged to stay unsigned
  assign w_credit_ok = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  // Late data for an aborted job must not land in the FIFO
  assign w_push      = ffrvld && (r_state == DRAIN) && !w_abort;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    err         = (r_state == IDLE) && start && !mode_legal(mode_in);
    ffinit      = w_start_ok || w_abort;
    ffwreq      = w_accept;
    ffwdata     = w_accept ? bus.in_data : '0;
    ffrreq      = (r_state == DRAIN) && !w_rd_all && w_credit_ok && !w_abort;
    mode        = (r_state != IDLE) ? r_mode : MODE_NONE;
    bus.in_rdy  = (r_state == LOAD) && !w_abort;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = LOAD;
      LOAD: begin
        if (w_abort)                      w_state_nxt = IDLE;
        else if (w_accept && w_last_row)  w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_abort)                                                w_state_nxt = IDLE;
        else if (w_rd_all && (w_occ == 2'd0) && !r_inflight)        w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Job mode, row/read counters and the one-deep inflight tracker
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= MODE_NONE;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= ffrreq;
      if (w_start_ok)                r_mode <= mode_t'(mode_in);
      else if (w_state_nxt == IDLE)  r_mode <= MODE_NONE;

      if (w_abort)       r_wcnt <= '0;
      else if (w_accept) r_wcnt <= w_last_row ? '0 : r_wcnt + 1'b1;

      if (w_abort || (r_state == DONE)) r_rcnt <= '0;
      else if (ffrreq)                  r_rcnt <= r_rcnt + 1'b1;
    end
  end

  trp_ctrl_obuf #(
    .DW (c_dw)
  ) u_obuf (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (w_abort),
    .i_push      (w_push),
    .i_push_data (ffrdata),
    .i_pop       (w_pop),
    .o_out_vld   (w_ovld),
    .o_out_data  (w_odata),
    .o_occ       (w_occ)
  );

  assign bus.out_vld  = w_ovld;
  assign bus.out_data = w_odata;

endmodule

`default_nettype wire
